// File: rtl/dpram_port_arbiter.sv
// Round-robin arbiter sharing one dual-port RAM between requesters A and B.
// Write and read ports are arbitrated independently; same-address collisions are forwarded.
module dpram_port_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int RR_EN  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_wr_req,
    input  logic [ADDR_W-1:0] a_wr_addr,
    input  logic [DATA_W-1:0] a_wr_data,
    output logic              a_wr_gnt,
    input  logic              a_rd_req,
    input  logic [ADDR_W-1:0] a_rd_addr,
    output logic              a_rd_gnt,
    output logic              a_rd_valid,
    output logic [DATA_W-1:0] a_rd_data,
    input  logic              b_wr_req,
    input  logic [ADDR_W-1:0] b_wr_addr,
    input  logic [DATA_W-1:0] b_wr_data,
    output logic              b_wr_gnt,
    input  logic              b_rd_req,
    input  logic [ADDR_W-1:0] b_rd_addr,
    output logic              b_rd_gnt,
    output logic              b_rd_valid,
    output logic [DATA_W-1:0] b_rd_data,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_wr_addr,
    output logic [DATA_W-1:0] ram_data_in,
    output logic              ram_re,
    output logic [ADDR_W-1:0] ram_rd_addr,
    input  logic [DATA_W-1:0] ram_data_out
);

    // Pointer high means A won last on that port, so B is favoured on a tie.
    logic              wr_last_a;
    logic              rd_last_a;
    logic              a_wr_win, b_wr_win;
    logic              a_rd_win, b_rd_win;
    logic              rd_own_p1;
    logic              vld_p2;
    logic              own_p2;
    logic              byp_vld_p2;
    logic [DATA_W-1:0] byp_data_p2;
    logic [DATA_W-1:0] a_rd_hold;
    logic [DATA_W-1:0] b_rd_hold;
    logic [DATA_W-1:0] rd_sel;

    always_comb begin
        a_wr_win = 1'b0;
        b_wr_win = 1'b0;
        a_rd_win = 1'b0;
        b_rd_win = 1'b0;
        if (rst_n) begin
            if (a_wr_req && b_wr_req) begin
                if ((RR_EN != 0) && wr_last_a) b_wr_win = 1'b1;
                else                           a_wr_win = 1'b1;
            end else begin
                a_wr_win = a_wr_req;
                b_wr_win = b_wr_req;
            end
            if (a_rd_req && b_rd_req) begin
                if ((RR_EN != 0) && rd_last_a) b_rd_win = 1'b1;
                else                           a_rd_win = 1'b1;
            end else begin
                a_rd_win = a_rd_req;
                b_rd_win = b_rd_req;
            end
        end
    end

    assign a_wr_gnt = a_wr_win;
    assign b_wr_gnt = b_wr_win;
    assign a_rd_gnt = a_rd_win;
    assign b_rd_gnt = b_rd_win;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ram_we      <= 1'b0;
            ram_re      <= 1'b0;
            ram_wr_addr <= '0;
            ram_rd_addr <= '0;
            ram_data_in <= '0;
            wr_last_a   <= 1'b0;
            rd_last_a   <= 1'b0;
            rd_own_p1   <= 1'b0;
            vld_p2      <= 1'b0;
            own_p2      <= 1'b0;
            byp_vld_p2  <= 1'b0;
            byp_data_p2 <= '0;
            a_rd_hold   <= '0;
            b_rd_hold   <= '0;
        end else begin
            // Stage 1: winning command onto the RAM pins
            ram_we <= a_wr_win | b_wr_win;
            if (a_wr_win | b_wr_win) begin
                ram_wr_addr <= b_wr_win ? b_wr_addr : a_wr_addr;
                ram_data_in <= b_wr_win ? b_wr_data : a_wr_data;
                wr_last_a   <= a_wr_win;
            end
            ram_re    <= a_rd_win | b_rd_win;
            rd_own_p1 <= b_rd_win;
            if (a_rd_win | b_rd_win) begin
                ram_rd_addr <= b_rd_win ? b_rd_addr : a_rd_addr;
                rd_last_a   <= a_rd_win;
            end

            // Stage 2: read owner and collision bypass, aligned with RAM data
            vld_p2      <= ram_re;
            own_p2      <= rd_own_p1;
            byp_vld_p2  <= ram_we && ram_re && (ram_wr_addr == ram_rd_addr);
            byp_data_p2 <= ram_data_in;

            if (vld_p2 && !own_p2) a_rd_hold <= rd_sel;
            if (vld_p2 && own_p2)  b_rd_hold <= rd_sel;
        end
    end

    assign rd_sel     = byp_vld_p2 ? byp_data_p2 : ram_data_out;
    assign a_rd_valid = rst_n && vld_p2 && !own_p2;
    assign b_rd_valid = rst_n && vld_p2 && own_p2;
    assign a_rd_data  = a_rd_valid ? rd_sel : a_rd_hold;
    assign b_rd_data  = b_rd_valid ? rd_sel : b_rd_hold;

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Directed bench for dpram_port_arbiter with a read-before-write dual-port RAM model.
// A second instance with fixed priority shares the stimulus.
module tb_dpram_port_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       a_wr_req, b_wr_req, a_rd_req, b_rd_req;
    logic [7:0] a_wr_addr, a_wr_data, b_wr_addr, b_wr_data, a_rd_addr, b_rd_addr;
    logic       a_wr_gnt, b_wr_gnt, a_rd_gnt, b_rd_gnt, a_rd_valid, b_rd_valid;
    logic [7:0] a_rd_data, b_rd_data;
    logic       ram_we, ram_re;
    logic [7:0] ram_wr_addr, ram_data_in, ram_rd_addr, ram_data_out;

    logic       x_a_wr_gnt, x_b_wr_gnt, x_a_rd_gnt, x_b_rd_gnt, x_a_rd_valid, x_b_rd_valid;
    logic [7:0] x_a_rd_data, x_b_rd_data;
    logic       x_ram_we, x_ram_re;
    logic [7:0] x_ram_wr_addr, x_ram_data_in, x_ram_rd_addr;

    logic [7:0] mem [256];
    int         n_tests = 0;
    int         n_fail  = 0;

    always #5 clk = ~clk;

    dpram_port_arbiter #(.ADDR_W(8), .DATA_W(8), .RR_EN(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_wr_req(a_wr_req), .a_wr_addr(a_wr_addr), .a_wr_data(a_wr_data), .a_wr_gnt(a_wr_gnt),
        .a_rd_req(a_rd_req), .a_rd_addr(a_rd_addr), .a_rd_gnt(a_rd_gnt),
        .a_rd_valid(a_rd_valid), .a_rd_data(a_rd_data),
        .b_wr_req(b_wr_req), .b_wr_addr(b_wr_addr), .b_wr_data(b_wr_data), .b_wr_gnt(b_wr_gnt),
        .b_rd_req(b_rd_req), .b_rd_addr(b_rd_addr), .b_rd_gnt(b_rd_gnt),
        .b_rd_valid(b_rd_valid), .b_rd_data(b_rd_data),
        .ram_we(ram_we), .ram_wr_addr(ram_wr_addr), .ram_data_in(ram_data_in),
        .ram_re(ram_re), .ram_rd_addr(ram_rd_addr), .ram_data_out(ram_data_out)
    );

    dpram_port_arbiter #(.ADDR_W(8), .DATA_W(8), .RR_EN(0)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .a_wr_req(a_wr_req), .a_wr_addr(a_wr_addr), .a_wr_data(a_wr_data), .a_wr_gnt(x_a_wr_gnt),
        .a_rd_req(a_rd_req), .a_rd_addr(a_rd_addr), .a_rd_gnt(x_a_rd_gnt),
        .a_rd_valid(x_a_rd_valid), .a_rd_data(x_a_rd_data),
        .b_wr_req(b_wr_req), .b_wr_addr(b_wr_addr), .b_wr_data(b_wr_data), .b_wr_gnt(x_b_wr_gnt),
        .b_rd_req(b_rd_req), .b_rd_addr(b_rd_addr), .b_rd_gnt(x_b_rd_gnt),
        .b_rd_valid(x_b_rd_valid), .b_rd_data(x_b_rd_data),
        .ram_we(x_ram_we), .ram_wr_addr(x_ram_wr_addr), .ram_data_in(x_ram_data_in),
        .ram_re(x_ram_re), .ram_rd_addr(x_ram_rd_addr), .ram_data_out(ram_data_out)
    );

    // Read-before-write RAM: a same-edge read returns the old contents.
    always @(posedge clk) begin
        if (ram_re) ram_data_out <= mem[ram_rd_addr];
        if (ram_we) mem[ram_wr_addr] <= ram_data_in;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        ram_data_out = 8'h00;

        // Reset held 3 cycles with every request high
        rst_n = 1'b0;
        a_wr_req = 1'b1; b_wr_req = 1'b1; a_rd_req = 1'b1; b_rd_req = 1'b1;
        a_wr_addr = 8'h00; a_wr_data = 8'h00; b_wr_addr = 8'h00; b_wr_data = 8'h00;
        a_rd_addr = 8'h00; b_rd_addr = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_a_wr_gnt", a_wr_gnt, 0);
        chk("rst_b_wr_gnt", b_wr_gnt, 0);
        chk("rst_a_rd_gnt", a_rd_gnt, 0);
        chk("rst_b_rd_gnt", b_rd_gnt, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_ram_re", ram_re, 0);
        chk("rst_a_rd_valid", a_rd_valid, 0);
        chk("rst_b_rd_valid", b_rd_valid, 0);
        chk("rst_a_rd_data", a_rd_data, 0);
        chk("rst_b_rd_data", b_rd_data, 0);
        a_wr_req = 1'b0; b_wr_req = 1'b0; a_rd_req = 1'b0; b_rd_req = 1'b0;
        rst_n = 1'b1;
        step();
        chk("post_rst_ram_we", ram_we, 0);

        // Contended writes: round-robin A,B,A,B and fixed priority A,A,A,A
        a_wr_req = 1'b1; a_wr_addr = 8'h10; a_wr_data = 8'h11;
        b_wr_req = 1'b1; b_wr_addr = 8'h20; b_wr_data = 8'h21;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("rr_a_wr_gnt%0d", i), a_wr_gnt, (i % 2 == 0) ? 1 : 0);
            chk($sformatf("rr_b_wr_gnt%0d", i), b_wr_gnt, (i % 2 == 0) ? 0 : 1);
            chk($sformatf("fp_a_wr_gnt%0d", i), x_a_wr_gnt, 1);
            chk($sformatf("fp_b_wr_gnt%0d", i), x_b_wr_gnt, 0);
            if (i > 0) chk($sformatf("rr_wr_addr%0d", i), ram_wr_addr, (i % 2 == 1) ? 8'h10 : 8'h20);
            step();
        end
        a_wr_req = 1'b0; b_wr_req = 1'b0;
        step();

        // Lone A write 0x05 <= 0x06
        a_wr_req = 1'b1; a_wr_addr = 8'h05; a_wr_data = 8'h06;
        #1;
        chk("w1_a_wr_gnt", a_wr_gnt, 1);
        chk("w1_b_wr_gnt", b_wr_gnt, 0);
        step();
        a_wr_req = 1'b0;
        chk("w1_ram_we", ram_we, 1);
        chk("w1_ram_wr_addr", ram_wr_addr, 8'h05);
        chk("w1_ram_data_in", ram_data_in, 8'h06);
        step();
        chk("w1_ram_we_drop", ram_we, 0);

        // Write 0x03 <= 0x04, then B reads 0x03
        a_wr_req = 1'b1; a_wr_addr = 8'h03; a_wr_data = 8'h04;
        #1;
        chk("w2_a_wr_gnt", a_wr_gnt, 1);
        step();
        a_wr_req = 1'b0;
        b_rd_req = 1'b1; b_rd_addr = 8'h03;
        #1;
        chk("r1_b_rd_gnt", b_rd_gnt, 1);
        chk("r1_a_rd_gnt", a_rd_gnt, 0);
        step();
        b_rd_req = 1'b0;
        chk("r1_ram_re", ram_re, 1);
        chk("r1_ram_rd_addr", ram_rd_addr, 8'h03);
        chk("r1_b_rd_valid_early", b_rd_valid, 0);
        step();
        chk("r1_b_rd_valid", b_rd_valid, 1);
        chk("r1_b_rd_data", b_rd_data, 8'h04);
        chk("r1_a_rd_valid", a_rd_valid, 0);
        step();
        chk("r1_b_rd_valid_drop", b_rd_valid, 0);
        chk("r1_b_rd_data_hold", b_rd_data, 8'h04);

        // Same-cycle A write 0x07 <= 0x08 and B read 0x07: bypass
        a_wr_req = 1'b1; a_wr_addr = 8'h07; a_wr_data = 8'h08;
        b_rd_req = 1'b1; b_rd_addr = 8'h07;
        #1;
        chk("byp_a_wr_gnt", a_wr_gnt, 1);
        chk("byp_b_rd_gnt", b_rd_gnt, 1);
        step();
        a_wr_req = 1'b0; b_rd_req = 1'b0;
        step();
        chk("byp_b_rd_valid", b_rd_valid, 1);
        chk("byp_b_rd_data", b_rd_data, 8'h08);
        chk("byp_a_rd_data", a_rd_data, 8'h00);
        step();

        // Contended reads: B won last, so A first then B
        a_rd_req = 1'b1; a_rd_addr = 8'h03;
        b_rd_req = 1'b1; b_rd_addr = 8'h07;
        #1;
        chk("rrd_a_rd_gnt0", a_rd_gnt, 1);
        chk("rrd_b_rd_gnt0", b_rd_gnt, 0);
        step();
        chk("rrd_a_rd_gnt1", a_rd_gnt, 0);
        chk("rrd_b_rd_gnt1", b_rd_gnt, 1);
        step();
        a_rd_req = 1'b0; b_rd_req = 1'b0;
        chk("rrd_a_rd_valid", a_rd_valid, 1);
        chk("rrd_a_rd_data", a_rd_data, 8'h04);
        chk("rrd_b_rd_valid0", b_rd_valid, 0);
        step();
        chk("rrd_b_rd_valid1", b_rd_valid, 1);
        chk("rrd_b_rd_data", b_rd_data, 8'h08);
        chk("rrd_a_rd_valid_drop", a_rd_valid, 0);
        chk("rrd_a_rd_data_hold", a_rd_data, 8'h04);
        step();

        // A read granted, reset asserted at the edge ending T+1
        a_rd_req = 1'b1; a_rd_addr = 8'h03;
        #1;
        chk("mr_a_rd_gnt", a_rd_gnt, 1);
        step();
        a_rd_req = 1'b0;
        rst_n = 1'b0;
        chk("mr_ram_re", ram_re, 1);
        step();
        a_wr_req = 1'b1; a_wr_addr = 8'h09; a_wr_data = 8'h0A;
        #1;
        chk("mr_a_rd_valid", a_rd_valid, 0);
        chk("mr_a_rd_data", a_rd_data, 8'h00);
        chk("mr_b_rd_data", b_rd_data, 8'h00);
        chk("mr_ram_re_rst", ram_re, 0);
        chk("mr_ram_we_rst", ram_we, 0);
        chk("mr_ram_rd_addr", ram_rd_addr, 8'h00);
        chk("mr_ram_wr_addr", ram_wr_addr, 8'h00);
        chk("mr_ram_data_in", ram_data_in, 8'h00);
        chk("mr_a_wr_gnt", a_wr_gnt, 0);
        step();
        rst_n = 1'b1;
        #1;
        chk("mr_ram_we_after", ram_we, 0);
        chk("mr_a_wr_gnt_after", a_wr_gnt, 1);
        step();
        a_wr_req = 1'b0;
        chk("mr_ram_we_issue", ram_we, 1);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
